// File: rtl/hams_merge_sched.sv
// Sequencer for the 4-to-1 merge-sort stage: gates column sources into the sorter, drains its output FIFO.
// Optional perf counters (perf_cycles/perf_stall/perf_bp) are built when HAMS_SCHED_PERF_EN is defined.
module hams_merge_sched #(
    parameter int NUM_COLS = 4,
    parameter int LEN_W    = 9,
    parameter int DATA_W   = 64,
    parameter int TOT_W    = LEN_W + 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [NUM_COLS*LEN_W-1:0]    col_len,
    input  logic [NUM_COLS-1:0]          src_vld,
    input  logic [NUM_COLS*DATA_W-1:0]   src_data,
    output logic [NUM_COLS-1:0]          src_rdy,
    output logic [NUM_COLS-1:0]          srt_col_ena,
    output logic [NUM_COLS-1:0]          srt_push,
    output logic [NUM_COLS*DATA_W-1:0]   srt_data,
    input  logic                         srt_full,
    input  logic                         srt_empty,
    input  logic [DATA_W-1:0]            srt_dout,
    output logic                         srt_pop,
    output logic                         out_vld,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         out_rdy,
    output logic                         busy,
    output logic                         done
`ifdef HAMS_SCHED_PERF_EN
    ,
    output logic [31:0]                  perf_cycles,
    output logic [31:0]                  perf_stall,
    output logic [31:0]                  perf_bp
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_FIN} state_t;

    state_t                              r_state, w_nxt;
    logic [NUM_COLS-1:0][LEN_W-1:0]      r_len, r_push_cnt;
    logic [TOT_W-1:0]                    r_total, r_pop_cnt, w_tot_in;
    logic                                r_out_vld;
    logic [DATA_W-1:0]                   r_out_data;
    logic                                w_fill, w_busy, w_accept, w_abort, w_fill_done, w_last_acc;

    assign w_fill   = (r_state == S_FILL);
    assign w_busy   = w_fill || (r_state == S_DRAIN);
    // abort outranks a same-cycle start
    assign w_accept = (r_state == S_IDLE) && start && !abort;
    assign w_abort  = w_busy && abort;

    always_comb begin
        w_tot_in    = '0;
        w_fill_done = 1'b1;
        for (int i = 0; i < NUM_COLS; i++) begin
            w_tot_in = w_tot_in + TOT_W'(col_len[i*LEN_W +: LEN_W]);
            if (r_push_cnt[i] != r_len[i]) w_fill_done = 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_COLS; g++) begin : g_col
        assign srt_col_ena[g] = w_fill && (r_push_cnt[g] < r_len[g]);
        assign src_rdy[g]     = srt_col_ena[g] & ~srt_full;
        assign srt_push[g]    = src_vld[g] & src_rdy[g];
    end

    assign srt_data   = src_data;
    assign srt_pop    = w_busy && !srt_empty && (r_pop_cnt < r_total) && (!r_out_vld || out_rdy);
    assign w_last_acc = (r_pop_cnt == r_total) && (!r_out_vld || out_rdy);
    assign out_vld    = r_out_vld;
    assign out_data   = r_out_data;
    assign busy       = w_busy;
    assign done       = (r_state == S_FIN);

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_nxt = (w_tot_in == '0) ? S_FIN : S_FILL;
            S_FILL:  if (abort) w_nxt = S_IDLE; else if (w_fill_done) w_nxt = S_DRAIN;
            S_DRAIN: if (abort) w_nxt = S_IDLE; else if (w_last_acc) w_nxt = S_FIN;
            S_FIN:   w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_total    <= '0;
            r_push_cnt <= '0;
            r_pop_cnt  <= '0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_accept) begin
                r_len      <= col_len;
                r_total    <= w_tot_in;
                r_push_cnt <= '0;
                r_pop_cnt  <= '0;
            end else if (w_abort || r_state == S_FIN) begin
                r_push_cnt <= '0;
                r_pop_cnt  <= '0;
            end else begin
                for (int i = 0; i < NUM_COLS; i++)
                    if (srt_push[i]) r_push_cnt[i] <= r_push_cnt[i] + LEN_W'(1);
                if (srt_pop) r_pop_cnt <= r_pop_cnt + TOT_W'(1);
            end
            // output register holds its data until accepted or replaced by a fresh pop
            if (w_abort) begin
                r_out_vld <= 1'b0;
            end else if (srt_pop) begin
                r_out_vld  <= 1'b1;
                r_out_data <= srt_dout;
            end else if (out_rdy) begin
                r_out_vld <= 1'b0;
            end
        end
    end

`ifdef HAMS_SCHED_PERF_EN
    logic [31:0] r_perf_cycles, r_perf_stall, r_perf_bp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_cycles <= '0;
            r_perf_stall  <= '0;
            r_perf_bp     <= '0;
        end else if (w_accept) begin
            r_perf_cycles <= '0;
            r_perf_stall  <= '0;
            r_perf_bp     <= '0;
        end else begin
            if (w_busy && r_perf_cycles != '1) r_perf_cycles <= r_perf_cycles + 32'd1;
            if (w_fill && srt_full && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 32'd1;
            if (r_out_vld && !out_rdy && r_perf_bp != '1) r_perf_bp <= r_perf_bp + 32'd1;
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_stall  = r_perf_stall;
    assign perf_bp     = r_perf_bp;
`endif

endmodule
